// File: rtl/fft_ctrl.sv
// fft_ctrl: FFT stage/address sequencer with ping-pong banks and write-back delay line; FFT_CTRL_CYCLE_CNT_EN enables run_cycles
module fft_ctrl #(
  parameter int ADDRSIZE  = 3,
  parameter int NUMSTAGES = 5,
  parameter int PIPE_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_data,
  input  logic                ld_done,
  input  logic                en,
  output logic                rd_en,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic                wr_en,
  output logic [ADDRSIZE-1:0] wr_addr,
  output logic                bank_sel,
  output logic [2:0]          stage,
  output logic [ADDRSIZE-1:0] tw_idx,
  output logic                busy,
  output logic                done,
  output logic [15:0]         run_cycles
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, DRAIN, DONE} state_t;
  localparam logic [ADDRSIZE-1:0] LAST_ADDR  = '1;
  localparam logic [2:0]          LAST_STAGE = 3'(NUMSTAGES - 1);
  localparam logic [2:0]          LAST_DRAIN = 3'(PIPE_LAT - 1);
  state_t                              state_q, state_d;
  logic [ADDRSIZE-1:0]                 cnt_q, cnt_d;
  logic [2:0]                          stage_q, stage_d;
  logic [2:0]                          dcnt_q, dcnt_d;
  logic                                bank_q, bank_d;
  logic [PIPE_LAT-1:0]                 vld_q, vld_d;
  logic [PIPE_LAT-1:0][ADDRSIZE-1:0]   dla_q, dla_d;
  logic                                abort, start, stage_end;
  // Next-state logic; a dropped ld_data while busy overrides every other transition
  always_comb begin
    rd_en     = (state_q == RUN) && en;
    busy      = state_q inside {LOAD, READY, RUN, DRAIN};
    abort     = busy && !ld_data;
    start     = (state_q == IDLE) && ld_data;
    stage_end = (state_q == DRAIN) && (dcnt_q == LAST_DRAIN) && ld_data;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (ld_data) state_d = LOAD;
      LOAD:    if (ld_done) state_d = READY;
      READY:   if (en) state_d = RUN;
      RUN:     if (rd_en && cnt_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (stage_end) state_d = (stage_q == LAST_STAGE) ? DONE : RUN;
      DONE:    if (!ld_data) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // Address counter, drain timer, stage index and bank select
  always_comb begin
    cnt_d   = (start || stage_end || state_d == IDLE) ? '0 : cnt_q + ADDRSIZE'(rd_en);
    dcnt_d  = (state_q == DRAIN && !stage_end && !abort) ? dcnt_q + 3'd1 : 3'd0;
    stage_d = start ? 3'd0 : (stage_end && stage_q != LAST_STAGE) ? stage_q + 3'd1 : stage_q;
    bank_d  = start ? 1'b0 : bank_q ^ stage_end;
  end
  // Write-back delay line: each issued read re-emerges PIPE_LAT cycles later; abort flushes it
  always_comb begin
    vld_d    = '0;
    dla_d    = dla_q;
    vld_d[0] = rd_en && !abort;
    dla_d[0] = cnt_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      vld_d[i] = vld_q[i-1] && !abort;
      dla_d[i] = dla_q[i-1];
    end
  end
  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      stage_q <= '0;
      bank_q  <= 1'b0;
      vld_q   <= '0;
      dla_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      stage_q <= stage_d;
      bank_q  <= bank_d;
      vld_q   <= vld_d;
      dla_q   <= dla_d;
    end
  end
  assign rd_addr  = cnt_q;
  assign wr_en    = vld_q[PIPE_LAT-1];
  assign wr_addr  = dla_q[PIPE_LAT-1];
  assign bank_sel = bank_q;
  assign stage    = stage_q;
  assign tw_idx   = (32'(stage_q) >= ADDRSIZE) ? '0 : cnt_q << stage_q;
  assign done     = state_q == DONE;
`ifdef FFT_CTRL_CYCLE_CNT_EN
  logic [15:0] rc_q, rc_d;
  // Saturating RUN+DRAIN cycle counter, cleared when a transform starts running
  always_comb begin
    rc_d = (state_q == READY && state_d == RUN) ? 16'd0 :
           (state_q inside {RUN, DRAIN} && rc_q != 16'hFFFF) ? rc_q + 16'd1 : rc_q;
  end
  // Cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rc_q <= '0;
    else rc_q <= rc_d;
  end
  assign run_cycles = rc_q;
`else
  assign run_cycles = '0;
`endif
endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: randomized/directed checks of fft_ctrl against a transaction-level reference model
module tb_fft_ctrl;
  localparam int A = 3, NS = 5, PL = 2, N = 8;
  localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_RUN = 3, M_DRAIN = 4, M_DONE = 5;
`ifdef FFT_CTRL_CYCLE_CNT_EN
  localparam bit RC_ON = 1'b1;
`else
  localparam bit RC_ON = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, ld_data = 1'b0, ld_done = 1'b0, en = 1'b0;
  logic rd_en, wr_en, bank_sel, busy, done;
  logic [A-1:0] rd_addr, wr_addr, tw_idx;
  logic [2:0] stage;
  logic [15:0] run_cycles;
  int total = 0, bad = 0, cyc = 0;
  int m_mode, m_stage, m_addr, m_left, m_bank, m_rc;
  int q_due[$], q_addr[$];
  int obs_rd, obs_wr, first_rd, done_at, stall;

  fft_ctrl #(.ADDRSIZE(A), .NUMSTAGES(NS), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .ld_data(ld_data), .ld_done(ld_done), .en(en),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .bank_sel(bank_sel), .stage(stage), .tw_idx(tw_idx), .busy(busy),
    .done(done), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tw(input int s, input int a);
    return (s >= A) ? 0 : (a * (1 << s)) % N;
  endfunction

  task automatic reset_model();
    m_mode = M_IDLE; m_stage = 0; m_addr = 0; m_left = 0; m_bank = 0; m_rc = 0;
    q_due.delete(); q_addr.delete();
  endtask

  task automatic check_outputs();
    int exp_rd, exp_wr;
    exp_rd = (m_mode == M_RUN && en) ? 1 : 0;
    exp_wr = (q_due.size() > 0 && q_due[0] == cyc) ? 1 : 0;
    chk("rd_en", 32'(rd_en), 32'(exp_rd));
    chk("rd_addr", 32'(rd_addr), 32'(m_addr));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    if (exp_wr == 1) chk("wr_addr", 32'(wr_addr), 32'(q_addr[0]));
    chk("bank_sel", 32'(bank_sel), 32'(m_bank));
    chk("stage", 32'(stage), 32'(m_stage));
    chk("tw_idx", 32'(tw_idx), 32'(tw(m_stage, m_addr)));
    chk("busy", 32'(busy), 32'(m_mode >= M_LOAD && m_mode <= M_DRAIN));
    chk("done", 32'(done), 32'(m_mode == M_DONE));
    chk("run_cycles", 32'(run_cycles), RC_ON ? 32'(m_rc) : 32'd0);
    if (m_mode == M_RUN && m_stage == 2 && m_addr == 3) chk("tw_s2_a3", 32'(tw_idx), 32'd4);
    if (m_mode == M_RUN && m_stage == 3) chk("tw_s3", 32'(tw_idx), 32'd0);
    if (rd_en) obs_rd++;
    if (wr_en) obs_wr++;
    if (rd_en && first_rd < 0) first_rd = cyc;
    if (done && done_at < 0) done_at = cyc;
  endtask

  task automatic model_advance();
    bit rd;
    rd = (m_mode == M_RUN) && en;
    if (rd) begin q_due.push_back(cyc + PL); q_addr.push_back(m_addr); end
    if (q_due.size() > 0 && q_due[0] == cyc) begin void'(q_due.pop_front()); void'(q_addr.pop_front()); end
    if ((m_mode == M_RUN || m_mode == M_DRAIN) && m_rc < 65535) m_rc++;
    cyc++;
    if (m_mode >= M_LOAD && m_mode <= M_DRAIN && !ld_data) begin
      m_mode = M_IDLE; m_addr = 0; q_due.delete(); q_addr.delete();
    end else if (m_mode == M_IDLE) begin
      if (ld_data) begin m_mode = M_LOAD; m_stage = 0; m_bank = 0; m_addr = 0; end
    end else if (m_mode == M_LOAD) begin
      if (ld_done) m_mode = M_READY;
    end else if (m_mode == M_READY) begin
      if (en) begin m_mode = M_RUN; m_rc = 0; end
    end else if (m_mode == M_RUN) begin
      if (rd) begin
        if (m_addr == N - 1) begin m_mode = M_DRAIN; m_left = PL; end
        m_addr = (m_addr + 1) % N;
      end
    end else if (m_mode == M_DRAIN) begin
      m_left--;
      if (m_left == 0) begin
        m_bank = 1 - m_bank; m_addr = 0;
        if (m_stage < NS - 1) begin m_stage++; m_mode = M_RUN; end
        else m_mode = M_DONE;
      end
    end else if (m_mode == M_DONE) begin
      if (!ld_data) m_mode = M_IDLE;
    end
  endtask

  task automatic step(input logic ld, input logic ldd, input logic e);
    ld_data = ld; ld_done = ldd; en = e;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic clear_tally();
    obs_rd = 0; obs_wr = 0; first_rd = -1; done_at = -1;
  endtask

  initial begin
    clear_tally();
    reset_model();
    #1 rst_n = 1'b0;
    #1;
    check_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rc", 32'(run_cycles), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Scenario 1: full unstalled transform
    clear_tally();
    step(1, 0, 1);
    step(1, 1, 1);
    for (int i = 0; i < 120 && m_mode != M_DONE; i++) step(1, 0, 1);
    step(1, 0, 1);
    chk("s1_rd_count", 32'(obs_rd), 32'(NS * N));
    chk("s1_wr_count", 32'(obs_wr), 32'(NS * N));
    chk("s1_done_latency", 32'(done_at - first_rd), 32'(NS * (N + PL)));
    chk("s1_bank_sel", 32'(bank_sel), 32'd1);
    chk("s1_run_cycles", 32'(run_cycles), RC_ON ? 32'd50 : 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("s1_bank_kept_idle", 32'(bank_sel), 32'd1);

    // Scenario 2: 3-cycle stall with rd_addr at 4 in stage 0
    clear_tally();
    stall = 0;
    step(1, 0, 1);
    step(1, 1, 1);
    for (int i = 0; i < 150 && m_mode != M_DONE; i++) begin
      if (m_mode == M_RUN && m_stage == 0 && m_addr == 4 && stall < 3) begin
        stall++;
        step(1, 0, 0);
      end else step(1, 0, 1);
    end
    step(1, 0, 1);
    chk("s2_done_latency", 32'(done_at - first_rd), 32'd53);
    chk("s2_wr_count", 32'(obs_wr), 32'(NS * N));
    step(0, 0, 0);

    // Scenario 3: random stalls, abort during stage 1, then a full random reload
    clear_tally();
    step(1, 0, 1);
    step(1, 1, 1);
    for (int i = 0; i < 300 && !(m_mode == M_RUN && m_stage == 1 && m_addr == 3); i++)
      step(1, 0, $urandom_range(0, 3) != 0);
    chk("s3_reached_stage1", 32'(stage), 32'd1);
    step(0, 0, 1);
    obs_wr = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    chk("s3_abort_no_wr", 32'(obs_wr), 32'd0);
    chk("s3_abort_busy", 32'(busy), 32'd0);
    step(1, 0, 0);
    chk("s3_reload_stage", 32'(stage), 32'd0);
    chk("s3_reload_bank", 32'(bank_sel), 32'd0);
    clear_tally();
    step(1, 1, 0);
    for (int i = 0; i < 400 && m_mode != M_DONE; i++) step(1, 0, $urandom_range(0, 3) != 0);
    step(1, 0, $urandom_range(0, 1) != 0);
    chk("s3_done_seen", 32'(done_at >= 0), 32'd1);
    chk("s3_wr_count", 32'(obs_wr), 32'(NS * N));
    step(0, 0, 0);

    // Scenario 4: reset asserted in DRAIN
    step(1, 0, 1);
    step(1, 1, 1);
    for (int i = 0; i < 100 && m_mode != M_DRAIN; i++) step(1, 0, 1);
    chk("s4_in_drain_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_rd_en", 32'(rd_en), 32'd0);
    chk("s4_rst_wr_en", 32'(wr_en), 32'd0);
    chk("s4_rst_busy", 32'(busy), 32'd0);
    chk("s4_rst_done", 32'(done), 32'd0);
    chk("s4_rst_bank", 32'(bank_sel), 32'd0);
    chk("s4_rst_stage", 32'(stage), 32'd0);
    chk("s4_rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("s4_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("s4_rst_tw_idx", 32'(tw_idx), 32'd0);
    chk("s4_rst_rc", 32'(run_cycles), 32'd0);
    reset_model();
    step(0, 0, 1);
    step(0, 0, 1);
    rst_n = 1'b1;
    obs_wr = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk("s4_no_wr_after_rst", 32'(obs_wr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter ADDRSIZE, default 3: RAM address width; each stage visits 2^ADDRSIZE word-groups (8 = 32 samples / 4 lanes).
REQ-002 Parameter NUMSTAGES, default 5: butterfly stages per transform.
REQ-003 Parameter PIPE_LAT, default 2: butterfly datapath latency in cycles, range 1..7.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ld_data  in  1  host request to load RAM and run; level, held high for the whole transform.
REQ-007 ld_done  in  1  RAM initializer finished loading; single-cycle pulse or level.
REQ-008 en  in  1  run enable; low stalls read issue.
REQ-009 rd_en / rd_addr  out  1 / ADDRSIZE  datapath read strobe and address.
REQ-010 wr_en / wr_addr  out  1 / ADDRSIZE  datapath write-back strobe and address.
REQ-011 bank_sel  out  1  ping-pong select: read bank = bank_sel, write bank = ~bank_sel.
REQ-012 stage  out  3  current stage index, 0..NUMSTAGES-1.
REQ-013 tw_idx  out  ADDRSIZE  twiddle ROM index for the current read.
REQ-014 busy / done  out  1 / 1  transform in progress / result valid.
REQ-015 run_cycles  out  16  cycles spent in RUN+DRAIN for the last transform.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, READY, RUN, DRAIN, DONE.
REQ-017 IDLE->LOAD when ld_data=1; LOAD->READY when ld_done=1; READY->RUN when en=1.
REQ-018 In RUN with en=1: rd_en=1, rd_addr = counter, counter increments each cycle starting at 0 on first RUN cycle.
REQ-019 In RUN with en=0: rd_en=0, counter and rd_addr hold; in-flight writes still complete.
REQ-020 After the read at address 2^ADDRSIZE-1 is issued, the FSM SHALL enter DRAIN for exactly PIPE_LAT cycles; en is ignored in DRAIN.
REQ-021 Every read issued at cycle t SHALL produce wr_en=1 with wr_addr equal to that rd_addr at cycle t+PIPE_LAT (delay line, no other write source).
REQ-022 End of DRAIN: bank_sel toggles, counter clears; if stage < NUMSTAGES-1, stage increments and FSM returns to RUN, else FSM enters DONE with stage held.
REQ-023 tw_idx = (rd_addr << stage) truncated to ADDRSIZE bits; 0 when stage >= ADDRSIZE.
REQ-024 busy=1 in LOAD, READY, RUN, DRAIN; done=1 only in DONE.
REQ-025 DONE->IDLE when ld_data=0; bank_sel retains value so host reads the result bank.
REQ-026 ld_data=0 in LOAD, READY, RUN or DRAIN SHALL abort to IDLE next cycle; delay line flushed, no further wr_en.
REQ-027 Unstalled transform SHALL take NUMSTAGES*(2^ADDRSIZE+PIPE_LAT) cycles from first RUN cycle to DONE (50 at defaults).
REQ-028 Entering LOAD from IDLE SHALL reset bank_sel, stage, counter to 0.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately: rd_en, wr_en, busy, done, bank_sel, stage, rd_addr, wr_addr, tw_idx, run_cycles all 0, delay line cleared.
REQ-030 Reset mid-RUN SHALL suppress all pending writes; no wr_en until a new transform.

Configuration
REQ-031 Macro FFT_CTRL_CYCLE_CNT_EN defined: run_cycles clears on entry to RUN from READY, increments each RUN/DRAIN cycle (saturating at 16'hFFFF), freezes in DONE and IDLE.
REQ-032 Macro undefined: run_cycles tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-033 Reset, ld_data=1, ld_done pulse, en=1 held -> 40 rd_en cycles, 40 wr_en cycles each 2 after its read, done at cycle 50, bank_sel=1, run_cycles=50 (macro on).
REQ-034 en low 3 cycles after rd_addr=4 in stage 0 -> rd_addr holds 4 (rd_en=0), writes for addr 2,3 still appear, done at cycle 53.
REQ-035 Stage 2, rd_addr=3 -> tw_idx=4; stage 3, any rd_addr -> tw_idx=0.
REQ-036 ld_data dropped during stage 1 RUN -> IDLE next cycle, wr_en stays 0, busy=0; new load restarts with stage=0, bank_sel=0.
REQ-037 rst_n asserted mid-DRAIN -> all outputs 0 same cycle, no wr_en after release; macro off -> run_cycles=0 throughout scenario 1.
